inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 8, meaning the entry count; it is a power of two and at least 4.
REQ-002 SHALL provide clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL provide resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide flush  input  1  discard all entries (branch redirect or exception).
REQ-005 SHALL provide in_valid  input  2  fetch slots valid; bit0 is slot0, bit1 is slot1.
REQ-006 SHALL provide in_pc0, in_inst0, in_pc1, in_inst1  input  32 each  fetched PC/instruction pairs.
REQ-007 SHALL provide in_ready  output  1  queue can accept two instructions this cycle.
REQ-008 SHALL provide out_valid0, out_valid1  output  1 each  head and head+1 entries present.
REQ-009 SHALL provide out_pc0, out_inst0, out_pc1, out_inst1  output  32 each  head and head+1 PC/instruction to decode.
REQ-010 SHALL provide out_ack  input  2  decode consumption; 2'b01 pops one, 2'b11 pops two.
REQ-011 SHALL provide count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-012 SHALL store entries as {pc, inst} in a circular buffer with head and tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
REQ-013 SHALL drive in_ready = 1 when registered count <= DEPTH-2, with no credit taken for a same-cycle pop.
REQ-014 SHALL push one entry (slot0) when in_ready, in_valid == 2'b01 and flush == 0.
REQ-015 SHALL push two entries (slot0 at tail, slot1 at tail+1) when in_ready, in_valid == 2'b11 and flush == 0.
REQ-016 SHALL ignore in_valid == 2'b10, in_valid == 2'b00, and any push while in_ready == 0; nothing is written in these cases.
REQ-017 SHALL present outputs show-ahead and combinationally from head/head+1, so an entry written at edge N appears at out_* after edge N (one-cycle write-to-visible latency).
REQ-018 SHALL drive out_valid0 = (count >= 1) and out_valid1 = (count >= 2).
REQ-019 SHALL force out_pc0/out_inst0 to 32'h0 when out_valid0 == 0, and out_pc1/out_inst1 to 32'h0 when out_valid1 == 0; 32'h0 is a NOP for the decoder.
REQ-020 SHALL compute pop count as min(ack count, occupancy); out_ack == 2'b10 pops nothing, and 2'b11 with count == 1 pops one.
REQ-021 SHALL update count_next = count + push_cnt - pop_cnt, with push and pop in the same cycle both applied.
REQ-022 SHALL never overflow (count <= DEPTH) and never underflow (count >= 0) under any input combination.
REQ-023 SHALL give flush priority over push and pop when asserted: head, tail and count go to 0 at the next edge, and that cycle's push and pop are discarded.
REQ-024 SHALL preserve FIFO order, so instructions leave in exact push order with slot0 ahead of slot1.
REQ-025 SHALL support full pointer wrap-around with no bubble or reordering at the DEPTH-1 to 0 boundary.

Reset
REQ-026 SHALL set head = 0, tail = 0 and count = 0 immediately when resetn is low, independent of clk.
REQ-027 SHALL, while in reset, produce out_valid0 = out_valid1 = 0, all out_pc/out_inst = 0 and in_ready = 1.
REQ-028 SHALL leave storage contents unreset, because they are unobservable while their valid bits are low.
REQ-029 SHALL, if reset asserts mid-operation, discard all entries, and the first post-reset push reads back at head.

Verification
REQ-030 SHALL cover dual push then dual pop: push (0x100, A) and (0x104, B) with 2'b11 -> next cycle out_valid0/1 = 1, out_pc0 = 0x100, out_pc1 = 0x104; ack 2'b11 -> count = 0.
REQ-031 SHALL cover fill to full: four dual pushes with DEPTH = 8 -> count = 8, in_ready = 0; a fifth push is ignored and count stays 8.
REQ-032 SHALL cover simultaneous push and pop: count = 6, push 2'b11 and ack 2'b01 in the same cycle -> in_ready = 1, count = 7, head advances by one.
REQ-033 SHALL cover partial ack: count = 1, ack 2'b11 -> pops one, count = 0, and out_inst0 and out_inst1 both read 32'h0.
REQ-034 SHALL cover flush priority: count = 5, flush with push 2'b11 and ack 2'b11 in the same cycle -> count = 0, outputs invalid, and the next push appears at out_pc0.
REQ-035 SHALL cover wrap-around: stream 20 sequential PCs 0x0 to 0x4C with random acks -> output PC sequence is strictly +4 and identical to the input sequence.

Source files
------------

// File: rtl/inst_queue.sv
// Dual-issue instruction queue: a circular buffer of {pc, inst} entries that accepts
// up to two fetched instructions per cycle and presents head/head+1 show-ahead to decode.
module inst_queue #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush,
   input  logic [1:0]               in_valid,
   input  logic [31:0]              in_pc0,
   input  logic [31:0]              in_inst0,
   input  logic [31:0]              in_pc1,
   input  logic [31:0]              in_inst1,
   output logic                     in_ready,
   output logic                     out_valid0,
   output logic                     out_valid1,
   output logic [31:0]              out_pc0,
   output logic [31:0]              out_inst0,
   output logic [31:0]              out_pc1,
   output logic [31:0]              out_inst1,
   input  logic [1:0]               out_ack,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] head_r;
   logic [AW-1:0] tail_r;
   logic [CW-1:0] count_r;
   logic [AW-1:0] head_p1_s;
   logic [AW-1:0] tail_p1_s;
   logic [CW-1:0] push_cnt_s;
   logic [CW-1:0] pop_cnt_s;
   logic          in_ready_s;
   logic [63:0]   rd0_s;
   logic [63:0]   rd1_s;

   // Decode can never take more than what is actually present.
   function automatic logic [CW-1:0] pop_amount(input logic [1:0] ack, input logic [CW-1:0] occ);
      logic [CW-1:0] req;
      case (ack)
         2'b01:   req = CW'(1);
         2'b11:   req = CW'(2);
         default: req = '0;
      endcase
      if (req > occ) begin
         pop_amount = occ;
      end else begin
         pop_amount = req;
      end
   endfunction

   assign head_p1_s  = head_r + AW'(1);
   assign tail_p1_s  = tail_r + AW'(1);
   assign in_ready_s = (count_r <= CW'(DEPTH - 2));

   // Push/pop amounts for this cycle; flush discards both.
   always_comb begin
      push_cnt_s = '0;
      pop_cnt_s  = '0;
      if (flush) begin
         push_cnt_s = '0;
         pop_cnt_s  = '0;
      end else begin
         if (in_ready_s) begin
            case (in_valid)
               2'b01:   push_cnt_s = CW'(1);
               2'b11:   push_cnt_s = CW'(2);
               default: push_cnt_s = '0;
            endcase
         end else begin
            push_cnt_s = '0;
         end
         pop_cnt_s = pop_amount(out_ack, count_r);
      end
   end

   // Pointer and occupancy state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else if (flush) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         head_r  <= head_r + pop_cnt_s[AW-1:0];
         tail_r  <= tail_r + push_cnt_s[AW-1:0];
         count_r <= count_r + push_cnt_s - pop_cnt_s;
      end
   end

   // Storage is left unreset: entries are invisible until count covers them.
   always_ff @(posedge clk) begin
      if (push_cnt_s != '0) begin
         mem[tail_r] <= {in_pc0, in_inst0};
      end
      if (push_cnt_s == CW'(2)) begin
         mem[tail_p1_s] <= {in_pc1, in_inst1};
      end
   end

   assign rd0_s = mem[head_r];
   assign rd1_s = mem[head_p1_s];

   // Show-ahead outputs, zeroed (NOP) whenever the slot is empty.
   always_comb begin
      out_valid0 = (count_r >= CW'(1));
      out_valid1 = (count_r >= CW'(2));
      out_pc0    = 32'h0;
      out_inst0  = 32'h0;
      out_pc1    = 32'h0;
      out_inst1  = 32'h0;
      if (out_valid0) begin
         out_pc0   = rd0_s[63:32];
         out_inst0 = rd0_s[31:0];
      end else begin
         out_pc0   = 32'h0;
         out_inst0 = 32'h0;
      end
      if (out_valid1) begin
         out_pc1   = rd1_s[63:32];
         out_inst1 = rd1_s[31:0];
      end else begin
         out_pc1   = 32'h0;
         out_inst1 = 32'h0;
      end
   end

   assign in_ready = in_ready_s;
   assign count    = count_r;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: accepted pushes are queued as expected entries and
// compared against the head/head+1 outputs every cycle; pops retire them.
module tb_inst_queue;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          resetn;
   logic          flush;
   logic [1:0]    in_valid;
   logic [31:0]   in_pc0, in_inst0, in_pc1, in_inst1;
   logic          in_ready;
   logic          out_valid0, out_valid1;
   logic [31:0]   out_pc0, out_inst0, out_pc1, out_inst1;
   logic [1:0]    out_ack;
   logic [CW-1:0] count;

   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] sb[$];
   logic [31:0] out_log[$];

   inst_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid),
      .in_pc0(in_pc0), .in_inst0(in_inst0), .in_pc1(in_pc1), .in_inst1(in_inst1),
      .in_ready(in_ready), .out_valid0(out_valid0), .out_valid1(out_valid1),
      .out_pc0(out_pc0), .out_inst0(out_inst0), .out_pc1(out_pc1), .out_inst1(out_inst1),
      .out_ack(out_ack), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock cycle: drive, compare outputs against the scoreboard, clock, update the model.
   task automatic cycle(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] i0,
                        input logic [31:0] p1, input logic [31:0] i1,
                        input logic [1:0] ack, input logic fl);
      int sz;
      int nack;
      int npop;
      logic [63:0] e0;
      logic [63:0] e1;
      in_valid = v; in_pc0 = p0; in_inst0 = i0; in_pc1 = p1; in_inst1 = i1;
      out_ack = ack; flush = fl;
      sz = sb.size();
      e0 = (sz >= 1) ? sb[0] : 64'h0;
      e1 = (sz >= 2) ? sb[1] : 64'h0;
      check_val("count", 64'(count), 64'(sz));
      check_val("in_ready", 64'(in_ready), 64'(sz <= DEPTH - 2));
      check_val("out_valid0", 64'(out_valid0), 64'(sz >= 1));
      check_val("out_valid1", 64'(out_valid1), 64'(sz >= 2));
      check_val("out_pc0", 64'(out_pc0), 64'(e0[63:32]));
      check_val("out_inst0", 64'(out_inst0), 64'(e0[31:0]));
      check_val("out_pc1", 64'(out_pc1), 64'(e1[63:32]));
      check_val("out_inst1", 64'(out_inst1), 64'(e1[31:0]));
      nack = (ack == 2'b01) ? 1 : (ack == 2'b11) ? 2 : 0;
      npop = (nack > sz) ? sz : nack;
      if (!fl && npop >= 1) out_log.push_back(out_pc0);
      if (!fl && npop >= 2) out_log.push_back(out_pc1);
      @(posedge clk); #1;
      if (fl) begin
         sb.delete();
      end else begin
         for (int k = 0; k < npop; k++) void'(sb.pop_front());
         if (sz <= DEPTH - 2 && (v == 2'b01 || v == 2'b11)) sb.push_back({p0, i0});
         if (sz <= DEPTH - 2 && v == 2'b11) sb.push_back({p1, i1});
      end
      in_valid = 2'b00; out_ack = 2'b00; flush = 1'b0;
   endtask

   task automatic idle();
      cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);
   endtask

   initial begin
      int idx;
      int budget;
      logic [1:0] v;
      logic [1:0] ack;
      resetn = 1'b0; flush = 1'b0; in_valid = 2'b00; out_ack = 2'b00;
      in_pc0 = 32'h0; in_inst0 = 32'h0; in_pc1 = 32'h0; in_inst1 = 32'h0;
      #2;
      check_val("rst_count", 64'(count), 64'd0);
      check_val("rst_in_ready", 64'(in_ready), 64'd1);
      check_val("rst_valid0", 64'(out_valid0), 64'd0);
      check_val("rst_valid1", 64'(out_valid1), 64'd0);
      check_val("rst_pc0", 64'(out_pc0), 64'd0);
      check_val("rst_inst1", 64'(out_inst1), 64'd0);
      @(posedge clk); #1;
      resetn = 1'b1;

      // dual push then dual pop
      cycle(2'b11, 32'h100, 32'hAAAA_0001, 32'h104, 32'hBBBB_0002, 2'b00, 1'b0);
      cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 1'b0);
      idle();

      // fill to full, fifth push ignored
      for (int k = 0; k < 5; k++)
         cycle(2'b11, 32'h1000 + 32'(16 * k), 32'hC000_0000 + 32'(2 * k),
               32'h1008 + 32'(16 * k), 32'hC000_0001 + 32'(2 * k), 2'b00, 1'b0);
      check_val("full_count", 64'(count), 64'd8);
      check_val("full_in_ready", 64'(in_ready), 64'd0);
      idle();

      // simultaneous push and pop at count 6
      cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0);
      cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0);
      cycle(2'b11, 32'h2000, 32'hD000_0000, 32'h2004, 32'hD000_0001, 2'b01, 1'b0);
      check_val("pushpop_count", 64'(count), 64'd7);
      idle();

      // drain to 1, then partial ack of 2'b11
      for (int k = 0; k < 3; k++) cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 1'b0);
      cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 1'b0);
      check_val("partial_count", 64'(count), 64'd0);
      check_val("partial_inst0", 64'(out_inst0), 64'd0);
      check_val("partial_inst1", 64'(out_inst1), 64'd0);

      // flush priority at count 5
      cycle(2'b11, 32'h3000, 32'hE000_0000, 32'h3004, 32'hE000_0001, 2'b00, 1'b0);
      cycle(2'b11, 32'h3008, 32'hE000_0002, 32'h300C, 32'hE000_0003, 2'b00, 1'b0);
      cycle(2'b01, 32'h3010, 32'hE000_0004, 32'h0, 32'h0, 2'b00, 1'b0);
      cycle(2'b11, 32'h3014, 32'hE000_0005, 32'h3018, 32'hE000_0006, 2'b11, 1'b1);
      check_val("flush_count", 64'(count), 64'd0);
      cycle(2'b01, 32'h3100, 32'hE100_0000, 32'h0, 32'h0, 2'b00, 1'b0);
      check_val("flush_next_pc0", 64'(out_pc0), 64'h3100);

      // slot1-only valid and ack 2'b10 do nothing
      cycle(2'b10, 32'h3200, 32'hE200_0000, 32'h3204, 32'hE200_0001, 2'b10, 1'b0);
      idle();
      cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 1'b0);

      // asynchronous reset mid-operation
      cycle(2'b11, 32'h4000, 32'hF000_0000, 32'h4004, 32'hF000_0001, 2'b00, 1'b0);
      cycle(2'b01, 32'h4008, 32'hF000_0002, 32'h0, 32'h0, 2'b00, 1'b0);
      resetn = 1'b0;
      #2;
      check_val("async_rst_count", 64'(count), 64'd0);
      check_val("async_rst_valid0", 64'(out_valid0), 64'd0);
      check_val("async_rst_in_ready", 64'(in_ready), 64'd1);
      sb.delete();
      @(posedge clk); #1;
      resetn = 1'b1;
      cycle(2'b01, 32'h5000, 32'h1234_5678, 32'h0, 32'h0, 2'b00, 1'b0);
      check_val("post_rst_pc0", 64'(out_pc0), 64'h5000);
      cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0);

      // stream 20 sequential PCs with random acks across the wrap boundary
      out_log.delete();
      idx = 0;
      budget = 0;
      while ((idx < 20 || sb.size() != 0) && budget < 300) begin
         if (idx >= 20) v = 2'b00;
         else if (idx == 19) v = 2'b01;
         else v = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
         ack = 2'($urandom_range(0, 3));
         if (sb.size() <= DEPTH - 2 && v != 2'b00) idx += (v == 2'b11) ? 2 : 1;
         cycle(v, 32'(4 * (idx - ((v == 2'b11) ? 2 : 1))), 32'hA000_0000 | 32'(4 * (idx - ((v == 2'b11) ? 2 : 1))),
               32'(4 * (idx - 1)), 32'hA000_0000 | 32'(4 * (idx - 1)), ack, 1'b0);
         budget++;
      end
      check_val("stream_budget", 64'(budget < 300), 64'd1);
      check_val("stream_len", 64'(out_log.size()), 64'd20);
      for (int k = 0; k < out_log.size(); k++)
         check_val("stream_pc", 64'(out_log[k]), 64'(4 * k));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
